// File: rtl/prio_grant_decoder.sv
// prio_grant_decoder
//   Return-path partner of an 8:3 priority encoder. Accepts a 3-bit winning
//   index, drives the matching one-hot grant and holds it under a 4-phase
//   req/ack handshake with the granted agent, then reports completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   idx_i, idx_valid  winning index and its qualifier
//   idx_ready         high while idle (an index can be accepted)
//   grant             registered one-hot grant (or zero)
//   grant_ack         per-agent 4-phase acknowledge
//   busy              high in GRANT or RELEASE
//   done_pulse        one-cycle pulse when the granted agent acks
//   done_idx          index of the last completed grant
//   spurious_ack      one-cycle pulse per GRANT cycle with a non-granted ack high
//   timeout_pulse     one-cycle pulse on grant abort
//   done_cnt          completed-grant count, wraps
//
// Optional feature: define PRIO_GRANT_TIMEOUT_EN to abort a grant after
// TIMEOUT_CYC cycles without the granted ack. Without it GRANT waits forever
// and timeout_pulse is tied low.

module prio_grant_decoder #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       idx_i,
    input  logic             idx_valid,
    output logic             idx_ready,
    output logic [7:0]       grant,
    input  logic [7:0]       grant_ack,
    output logic             busy,
    output logic             done_pulse,
    output logic [2:0]       done_idx,
    output logic             spurious_ack,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e             r_state, w_state_d;
    logic [2:0]         r_idx, w_idx_d;
    logic [7:0]         r_grant, w_grant_d;
    logic               r_done, w_done_d;
    logic [2:0]         r_done_idx, w_done_idx_d;
    logic               r_spur, w_spur_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;

    logic [7:0]         w_sel;
    logic               w_ack_hit;

    assign w_sel     = 8'b1 << r_idx;
    assign w_ack_hit = grant_ack[r_idx];

`ifdef PRIO_GRANT_TIMEOUT_EN
    logic [7:0] r_tcnt, w_tcnt_d;
    logic       r_tmo, w_tmo_d;
    logic       w_tmo_hit;

    // Counter holds the number of completed ack-less GRANT cycles, so the
    // abort fires on the edge that would make it reach TIMEOUT_CYC.
    assign w_tmo_hit = (r_tcnt == 8'(TIMEOUT_CYC - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_grant_d    = r_grant;
        w_done_d     = 1'b0;
        w_done_idx_d = r_done_idx;
        w_spur_d     = 1'b0;
        w_cnt_d      = r_cnt;
`ifdef PRIO_GRANT_TIMEOUT_EN
        w_tcnt_d     = r_tcnt;
        w_tmo_d      = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (idx_valid) begin
                    w_idx_d   = idx_i;
                    w_grant_d = 8'b1 << idx_i;
                    w_state_d = StGrant;
`ifdef PRIO_GRANT_TIMEOUT_EN
                    w_tcnt_d  = 8'd0;
`endif
                end
            end
            StGrant: begin
                w_spur_d = |(grant_ack & ~w_sel);
                // Ack takes precedence over a simultaneous timeout.
                if (w_ack_hit) begin
                    w_grant_d    = 8'd0;
                    w_done_d     = 1'b1;
                    w_done_idx_d = r_idx;
                    w_cnt_d      = r_cnt + CNT_W'(1);
                    w_state_d    = StRelease;
                end
`ifdef PRIO_GRANT_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_grant_d = 8'd0;
                    w_tmo_d   = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_tcnt_d = r_tcnt + 8'd1;
                end
`endif
            end
            StRelease: begin
                if (!w_ack_hit) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_idx      <= 3'd0;
            r_grant    <= 8'd0;
            r_done     <= 1'b0;
            r_done_idx <= 3'd0;
            r_spur     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_grant    <= w_grant_d;
            r_done     <= w_done_d;
            r_done_idx <= w_done_idx_d;
            r_spur     <= w_spur_d;
            r_cnt      <= w_cnt_d;
        end
    end

`ifdef PRIO_GRANT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= 8'd0;
            r_tmo  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_d;
            r_tmo  <= w_tmo_d;
        end
    end
    assign timeout_pulse = r_tmo;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign idx_ready    = (r_state == StIdle);
    assign busy         = (r_state != StIdle);
    assign grant        = r_grant;
    assign done_pulse   = r_done;
    assign done_idx     = r_done_idx;
    assign spurious_ack = r_spur;
    assign done_cnt     = r_cnt;

endmodule

// File: tb/tb_prio_grant_decoder.sv
// Self-checking bench for prio_grant_decoder. A transaction-level model
// (expected grant vector, completion count, spurious-ack rule) predicts every
// observed output; stimulus timing and extra ack bits are randomized.

module tb_prio_grant_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;

    logic             clk;
    logic             rst_n;
    logic [2:0]       idx_i;
    logic             idx_valid;
    logic             idx_ready;
    logic [7:0]       grant;
    logic [7:0]       grant_ack;
    logic             busy;
    logic             done_pulse;
    logic [2:0]       done_idx;
    logic             spurious_ack;
    logic             timeout_pulse;
    logic [CNT_W-1:0] done_cnt;

    int n_checks;
    int n_errors;
    int exp_cnt;

    prio_grant_decoder #(
        .TIMEOUT_CYC(TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_i        (idx_i),
        .idx_valid    (idx_valid),
        .idx_ready    (idx_ready),
        .grant        (grant),
        .grant_ack    (grant_ack),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .done_idx     (done_idx),
        .spurious_ack (spurious_ack),
        .timeout_pulse(timeout_pulse),
        .done_cnt     (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_mod(input int c);
        return 32'(c % (1 << CNT_W));
    endfunction

    // One clock: predict spurious_ack from the ack bits seen during a GRANT
    // cycle, advance, then check the pulse outputs.
    task automatic tick(input logic in_grant, input logic [2:0] idx);
        logic [7:0] sel;
        logic       exp_spur;
        sel      = 8'b1 << idx;
        exp_spur = in_grant && ((grant_ack & ~sel) != 8'd0);
        @(posedge clk);
        #1;
        check_eq("spurious", spurious_ack, exp_spur);
        check_eq("timeout_quiet", timeout_pulse, 0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_grant"}, grant, 0);
        check_eq({tag, "_ready"}, idx_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done_pulse, 0);
        check_eq({tag, "_cnt"}, done_cnt, cnt_mod(exp_cnt));
    endtask

    // Full handshake: accept, ack_dly ack-less GRANT cycles (random other
    // acks and ignored idx_valid), ack, rel_dly cycles with ack held, drop.
    task automatic txn(input logic [2:0] idx, input int ack_dly, input int rel_dly);
        logic [7:0] sel;
        sel = 8'b1 << idx;
        check_eq("pre_ready", idx_ready, 1);
        idx_i     = idx;
        idx_valid = 1'b1;
        grant_ack = 8'($urandom);
        tick(1'b0, idx);
        check_eq("acc_grant", grant, sel);
        check_eq("acc_ready", idx_ready, 0);
        check_eq("acc_busy", busy, 1);
        check_eq("acc_done", done_pulse, 0);
        for (int c = 0; c < ack_dly; c++) begin
            idx_valid = 1'($urandom);
            idx_i     = 3'($urandom);
            grant_ack = 8'($urandom) & ~sel;
            tick(1'b1, idx);
            check_eq("hold_grant", grant, sel);
            check_eq("hold_done", done_pulse, 0);
        end
        idx_valid = 1'($urandom);
        grant_ack = sel | (($urandom_range(0, 1) == 1) ? (8'($urandom) & ~sel) : 8'd0);
        tick(1'b1, idx);
        exp_cnt++;
        check_eq("ack_grant", grant, 0);
        check_eq("ack_done", done_pulse, 1);
        check_eq("ack_done_idx", done_idx, idx);
        check_eq("ack_cnt", done_cnt, cnt_mod(exp_cnt));
        check_eq("ack_busy", busy, 1);
        check_eq("ack_ready", idx_ready, 0);
        for (int r = 0; r < rel_dly; r++) begin
            grant_ack = sel | 8'($urandom);
            idx_valid = 1'($urandom);
            tick(1'b0, idx);
            check_eq("rel_grant", grant, 0);
            check_eq("rel_done", done_pulse, 0);
            check_eq("rel_busy", busy, 1);
            check_eq("rel_ready", idx_ready, 0);
        end
        grant_ack = 8'($urandom) & ~sel;
        idx_valid = 1'b0;
        tick(1'b0, idx);
        check_idle("end");
        grant_ack = 8'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        idx_i     = 3'd0;
        idx_valid = 1'b0;
        grant_ack = 8'd0;
        #3;
        check_idle("reset");
        check_eq("reset_spur", spurious_ack, 0);
        check_eq("reset_done_idx", done_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Acks in IDLE must change nothing.
        for (int i = 0; i < 8; i++) begin
            grant_ack = 8'($urandom);
            tick(1'b0, 3'd0);
            check_idle("idle_ack");
        end
        grant_ack = 8'd0;

        txn(3'd5, 3, 1);
        txn(3'd0, 0, 0);
        txn(3'd7, 0, 0);
        for (int i = 0; i < 12; i++) begin
            txn(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Grant without ack.
        idx_i     = 3'd3;
        idx_valid = 1'b1;
        tick(1'b0, 3'd3);
        idx_valid = 1'b0;
        check_eq("tmo_grant0", grant, 8'h08);
`ifdef PRIO_GRANT_TIMEOUT_EN
        for (int i = 1; i < int'(TMO); i++) begin
            tick(1'b1, 3'd3);
            check_eq("tmo_grant", grant, 8'h08);
        end
        @(posedge clk);
        #1;
        check_eq("tmo_drop", grant, 0);
        check_eq("tmo_pulse", timeout_pulse, 1);
        check_eq("tmo_nodone", done_pulse, 0);
        check_eq("tmo_ready", idx_ready, 1);
        check_eq("tmo_cnt", done_cnt, cnt_mod(exp_cnt));
        tick(1'b0, 3'd3);
        check_idle("tmo_after");
`else
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 3'd3);
        end
        check_eq("notmo_grant", grant, 8'h08);
        check_eq("notmo_busy", busy, 1);
        grant_ack = 8'h08;
        tick(1'b1, 3'd3);
        exp_cnt++;
        check_eq("notmo_done", done_pulse, 1);
        grant_ack = 8'h00;
        tick(1'b0, 3'd3);
        check_idle("notmo_end");
`endif

        // Asynchronous reset mid-GRANT.
        idx_i     = 3'd6;
        idx_valid = 1'b1;
        tick(1'b0, 3'd6);
        idx_valid = 1'b0;
        check_eq("rst_pre_grant", grant, 8'h40);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_idle("rst_async");
        check_eq("rst_spur", spurious_ack, 0);
        check_eq("rst_tmo", timeout_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(3'd1, 1, 0);

        // Counter wrap: 15 more completions bring a 4-bit count back to 0.
        for (int i = 0; i < 15; i++) begin
            txn(3'($urandom), $urandom_range(0, 1), 0);
        end
        check_eq("cnt_wrap", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
